// File: rtl/mem_io_responder_pkg.sv
// Shared constants, address decode and bus payload type for the memory/IO responder.
package mem_io_responder_pkg;

  localparam int unsigned ADDR_W                = 32;
  localparam int unsigned DATA_W                = 8;
  localparam int unsigned DECODE_W              = 18;
  localparam int unsigned RAM_ADDR_BITS_DEFAULT = 17;

  localparam logic [DECODE_W-1:0] IO_TX_ADDR  = 18'h30000;
  localparam logic [DECODE_W-1:0] IO_END_ADDR = 18'h30004;
  localparam logic [1:0]          IO_SEL      = 2'b11;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_IO_TX,
    SEL_IO_END,
    SEL_IO_NONE
  } addr_sel_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  // IO window is bits [17:16] == 2'b11; unknown IO addresses read 0 and ignore writes
  function automatic addr_sel_e decode_addr(input logic [DECODE_W-1:0] addr);
    addr_sel_e sel;
    if (addr[DECODE_W-1 -: 2] != IO_SEL) sel = SEL_RAM;
    else if (addr == IO_TX_ADDR)         sel = SEL_IO_TX;
    else if (addr == IO_END_ADDR)        sel = SEL_IO_END;
    else                                 sel = SEL_IO_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus between the memory controller (master) and the responder (slave).
interface mem_io_responder_if;

  logic                                       mem_rw;
  logic [mem_io_responder_pkg::ADDR_W-1:0]    mem_aout;
  logic [mem_io_responder_pkg::DATA_W-1:0]    mem_dout;
  logic [mem_io_responder_pkg::DATA_W-1:0]    mem_din;
  logic                                       io_buffer_full;

  modport master (
    output mem_rw, mem_aout, mem_dout,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_rw, mem_aout, mem_dout,
    output mem_din, io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_io_byte_fifo.sv
// Byte FIFO for the TX path with registered valid and near-full flags.
module io_byte_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wr_data,
  output logic [7:0]                 rd_data_c,
  output logic                       full_c,
  output logic                       valid,
  output logic                       near_full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && valid;
  // A push into a full FIFO still lands when the head leaves on the same edge
  assign do_push   = push && (!full_c || do_pop);
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid     <= 1'b0;
      near_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      valid     <= (count_nxt != '0);
      near_full <= ((CNT_W'(DEPTH) - count_nxt) <= CNT_W'(MARGIN));
    end
  end

  // Storage is not reset; pointer reset discards contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the byte-serial memory bus: unified byte RAM plus the TX/RX/END IO window.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS  = RAM_ADDR_BITS_DEFAULT,
  parameter int unsigned IO_FIFO_DEPTH  = 8,
  parameter int unsigned IO_FULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  mem_io_responder_if.slave   bus,
  output logic                io_tx_valid,
  output logic [DATA_W-1:0]   io_tx_data,
  input  logic                io_tx_ready,
  input  logic                io_rx_valid,
  input  logic [DATA_W-1:0]   io_rx_data,
  output logic                io_rx_pop,
  output logic                program_end,
  output logic                tx_overflow
);

  localparam int unsigned RAM_WORDS = 2 ** RAM_ADDR_BITS;

  logic [DATA_W-1:0]          ram [RAM_WORDS];
  mem_req_t                   req;
  addr_sel_e                  sel;
  logic [RAM_ADDR_BITS-1:0]   ram_idx;
  logic [DATA_W-1:0]          read_byte;
  logic [DATA_W-1:0]          mem_din_q;
  logic                       wr_en;
  logic                       rd_en;
  logic                       tx_push;
  logic                       tx_pop;
  logic                       tx_full_c;
  logic                       tx_near_full;
  logic [$clog2(IO_FIFO_DEPTH):0] unused_tx_count;
  logic                       unused_addr_hi;

  assign req            = '{rw: bus.mem_rw, addr: bus.mem_aout, data: bus.mem_dout};
  assign sel            = decode_addr(req.addr[DECODE_W-1:0]);
  assign ram_idx        = req.addr[RAM_ADDR_BITS-1:0];
  assign unused_addr_hi = ^req.addr[ADDR_W-1:DECODE_W];
  assign wr_en          = rdy_in && req.rw;
  assign rd_en          = rdy_in && !req.rw;
  assign tx_push        = wr_en && (sel == SEL_IO_TX);
  assign tx_pop         = rdy_in && io_tx_valid && io_tx_ready;

  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = tx_near_full;

  io_byte_fifo #(
    .DEPTH  (IO_FIFO_DEPTH),
    .MARGIN (IO_FULL_MARGIN)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst_in),
    .push      (tx_push),
    .pop       (tx_pop),
    .wr_data   (req.data),
    .rd_data_c (io_tx_data),
    .full_c    (tx_full_c),
    .valid     (io_tx_valid),
    .near_full (tx_near_full),
    .count     (unused_tx_count)
  );

  // Read-side source selection for the registered read port
  always_comb begin
    read_byte = '0;
    case (sel)
      SEL_RAM:    read_byte = ram[ram_idx];
      SEL_IO_TX:  read_byte = io_rx_valid ? io_rx_data : '0;
      SEL_IO_END: read_byte = {6'b0, tx_overflow, io_tx_valid};
      default:    read_byte = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      mem_din_q   <= '0;
      io_rx_pop   <= 1'b0;
      program_end <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      io_rx_pop <= rd_en && (sel == SEL_IO_TX) && io_rx_valid;
      if (wr_en)      mem_din_q <= '0;
      else if (rd_en) mem_din_q <= read_byte;
      if (wr_en && (sel == SEL_IO_END)) program_end <= 1'b1;
      if (tx_push && tx_full_c && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  // RAM holds its contents across reset
  always_ff @(posedge clk) begin
    if (wr_en && (sel == SEL_RAM)) ram[ram_idx] <= req.data;
  end

endmodule
